// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative multi-cycle multiply/divide unit for the Execute stage.
// It computes one bit per cycle over unsigned magnitudes and applies the sign
// fix-up on the final iteration.
//
// Ports:
//   CLK       clock, rising edge
//   Reset     asynchronous active-high reset; clears all state
//   Start     E-stage MUL/DIV whose condition passed
//   MCycleOp  00 signed MUL, 01 unsigned MUL, 10 signed DIV, 11 unsigned DIV
//   Operand1  multiplicand / dividend
//   Operand2  multiplier / divisor
//   Result1   MUL: product low half, DIV: quotient
//   Result2   MUL: product high half, DIV: remainder
//   Busy      stall request to the hazard unit (combinational)
//   Done      one-cycle pulse when Result1/Result2 are updated
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, COMPUTING} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic            div_q;        // 1: divide, 0: multiply
  logic            neg_res_q;    // operand signs differ (signed ops only)
  logic            neg_rem_q;    // dividend was negative (signed ops only)
  logic [WIDTH-1:0] hi_q;        // MUL: accumulator high half, DIV: partial remainder
  logic [WIDTH-1:0] lo_q;        // MUL: multiplier/product low, DIV: dividend/quotient
  logic [WIDTH-1:0] m_q;         // MUL: multiplicand magnitude, DIV: divisor magnitude
  logic [WIDTH-1:0] res1_q, res2_q;
  logic             done_q;

  logic start_accept;
  logic last_iter;

  assign start_accept = (state_q == IDLE) && Start;
  assign last_iter    = (state_q == COMPUTING) && (count_q == LAST);

  // Operand magnitudes and sign flags captured at start.
  logic             signed_op;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;

  assign signed_op = ~MCycleOp[0];
  assign s1        = signed_op & Operand1[WIDTH-1];
  assign s2        = signed_op & Operand2[WIDTH-1];
  assign mag1      = s1 ? -Operand1 : Operand1;
  assign mag2      = s2 ? -Operand2 : Operand2;

  // One shift-add multiply step: add multiplicand when multiplier LSB is set,
  // then shift the {carry, hi, lo} chain right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

  // One restoring divide step: shift the next dividend bit into the remainder
  // and keep the difference only when it did not go negative.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi, div_lo;

  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_hi    = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo    = {lo_q[WIDTH-2:0], div_ok};

  logic [WIDTH-1:0] hi_d, lo_d;
  assign hi_d = div_q ? div_hi : mul_hi;
  assign lo_d = div_q ? div_lo : mul_lo;

  // Signed fix-up on the final iteration's values.
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0]   quot_f, rem_f;

  assign prod   = {hi_d, lo_d};
  assign prod_f = neg_res_q ? -prod : prod;
  // A zero divisor always yields all ones, regardless of the dividend's sign.
  assign quot_f = (m_q == '0) ? '1 : (neg_res_q ? -lo_d : lo_d);
  assign rem_f  = neg_rem_q ? -hi_d : hi_d;

  // FSM: state register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (Start)     state_d = COMPUTING;
      COMPUTING: if (last_iter) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Busy = start_accept || (state_q == COMPUTING);
  end

  // Datapath
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count_q   <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_iter;
      if (start_accept) begin
        count_q   <= '0;
        div_q     <= MCycleOp[1];
        neg_res_q <= s1 ^ s2;
        neg_rem_q <= s1;
        hi_q      <= '0;
        lo_q      <= MCycleOp[1] ? mag1 : mag2;
        m_q       <= MCycleOp[1] ? mag2 : mag1;
      end else if (state_q == COMPUTING) begin
        count_q <= count_q + CW'(1);
        hi_q    <= hi_d;
        lo_q    <= lo_d;
        if (last_iter) begin
          if (div_q) begin
            res1_q <= quot_f;
            res2_q <= rem_f;
          end else begin
            res1_q <= prod_f[WIDTH-1:0];
            res2_q <= prod_f[2*WIDTH-1:WIDTH];
          end
        end
      end
    end
  end

  assign Result1 = res1_q;
  assign Result2 = res2_q;
  assign Done    = done_q;

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit sitting in the Execute stage beside the ALU.
- Accepts one MUL/DIV operation from E and computes it one bit per cycle.
- Drives Busy to the hazard unit, which holds F/D/E (StallF/StallD/StallE) while Busy=1.
- Results are muxed into the E-stage result path when the op completes.

Parameters:
WIDTH, 32, operand/result width in bits (≥4).

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  E-stage instruction is a MUL/DIV and its condition passed
MCycleOp  input  2  00 signed MUL, 01 unsigned MUL, 10 signed DIV, 11 unsigned DIV
Operand1  input  WIDTH  multiplicand / dividend
Operand2  input  WIDTH  multiplier / divisor
Result1  output  WIDTH  MUL: product low half; DIV: quotient
Result2  output  WIDTH  MUL: product high half; DIV: remainder
Busy  output  1  stall request to hazard unit
Done  output  1  one-cycle pulse; Result1/Result2 valid

Behaviour:
- States: IDLE, COMPUTING. Counter `count` has width clog2(WIDTH)+1.
- Reset (async, any time including mid-operation):
  - state=IDLE, count=0; Result1=0, Result2=0, Done=0.
  - All internal shift/accumulator registers are cleared.
  - No pending operation survives reset.
- Busy (combinational) = (state==IDLE & Start) | (state==COMPUTING).
  - Busy rises in the same cycle Start is presented, so the hazard unit stalls immediately.
- IDLE with Start=1:
  - Latch MCycleOp and operands; for signed ops, latch magnitudes plus sign flags.
  - count=0; go to COMPUTING.
- COMPUTING: one iteration per cycle, count++.
  - MUL: shift-add on a 2*WIDTH accumulator over unsigned magnitudes.
  - DIV: restoring shift-subtract over unsigned magnitudes.
- Final iteration (count==WIDTH-1):
  - Results are computed combinationally from the final iteration and registered into Result1/Result2.
  - Signed fix-up applied: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - state=IDLE; Done=1 for exactly the following cycle.
- Latency:
  - Start in cycle 0 → Busy=1 in cycles 0..WIDTH (WIDTH+1 cycles).
  - Cycle WIDTH+1: Busy=0, Done=1, results valid.
- Result1/Result2 hold their value until the next operation completes. A new Start does not clear them.
- Start while COMPUTING is ignored; operands and op are not re-latched.
- Start in the Done cycle (state IDLE) begins a new operation back-to-back; Busy=1 in that same cycle.
- Start deasserted mid-operation does not abort. Cancellation is only by Reset.
- Operands may change after the latch cycle without effect.
- Division by zero, unsigned: Result1 = all ones, Result2 = Operand1.
- Division by zero, signed: Result1 = all ones (-1), Result2 = Operand1.
- Signed overflow: most-negative / -1 gives Result1 = most-negative (wraps), Result2 = 0.
- MUL of most-negative × most-negative (signed): exact 2*WIDTH-bit product, no overflow.
- Done is never asserted except the cycle after a completed operation.

Test Plan (WIDTH=32):
1. Reset → Busy=0, Done=0, Result1=Result2=0. Unsigned MUL 0xFFFFFFFF × 0x00000002 with Start in cycle 0 → Busy high cycles 0..32; cycle 33: Done=1, Result1=0xFFFFFFFE, Result2=0x00000001.
2. Signed MUL -3 × 7 → Result1=0xFFFFFFEB, Result2=0xFFFFFFFF. Signed MUL 0x80000000 × 0x80000000 → Result1=0, Result2=0x40000000.
3. Signed DIV -7 / 2 → Result1=0xFFFFFFFD, Result2=0xFFFFFFFF. Unsigned DIV 100 / 7 → Result1=14, Result2=2.
4. Divide by zero: unsigned 0x1234 / 0 → Result1=0xFFFFFFFF, Result2=0x1234. Signed 0x80000000 / 0xFFFFFFFF → Result1=0x80000000, Result2=0.
5. Back-to-back and stray Start:
   - Start held high through the whole op with changing operands → operands are not re-latched and the result matches the first operands.
   - Second op starts in the Done cycle with Busy=1 that cycle; Done is asserted 33 cycles later.
6. Reset asserted asynchronously at cycle 10 of a DIV:
   - Busy and all outputs drop to 0 immediately; no Done pulse follows.
   - A subsequent Start completes normally.
